// File: rtl/hex_key_fifo.sv
// Keypad key queue: hold-off filter that suppresses repeats of a held key,
// followed by a first-word-fall-through FIFO with fill level and sticky overflow.
module hex_key_fifo #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned HOLDOFF_CYC = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [3:0]               key_code,
  input  logic                     key_valid,
  input  logic                     rd_en,
  input  logic                     ovf_clr,
  output logic [3:0]               rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = $clog2(HOLDOFF_CYC + 1);

  typedef enum logic {ARMED, HOLDOFF} state_t;

  state_t          state_q, state_d;
  logic [3:0]      last_code_q, last_code_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [3:0]      mem_q [DEPTH];
  logic [3:0]      mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;

  logic accept, push, pop, drop;

  always_comb begin
    state_d     = state_q;
    last_code_d = last_code_q;
    timer_d     = timer_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;

    accept = key_valid && ((state_q == ARMED) || (key_code != last_code_q));
    pop    = rd_en && (count_q != '0);
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    push   = accept && ((count_q != CW'(DEPTH)) || pop);
    drop   = accept && !push;

    // Any key_valid either accepts or reloads the hold-off on a repeated code.
    if (key_valid) begin
      timer_d = TW'(HOLDOFF_CYC);
      state_d = HOLDOFF;
      if (accept) last_code_d = key_code;
    end else if (state_q == HOLDOFF) begin
      if (timer_q == TW'(1)) begin
        timer_d = '0;
        state_d = ARMED;
      end else begin
        timer_d = timer_q - TW'(1);
      end
    end

    if (push) begin
      mem_d[wr_ptr_q] = key_code;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);

    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);

    if (drop)         overflow_d = 1'b1;
    else if (ovf_clr) overflow_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ARMED;
      last_code_q <= '0;
      timer_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_code_q <= last_code_d;
      timer_q     <= timer_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage needs no reset: reads are gated by the count.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign count    = count_q;
  assign overflow = overflow_q;
  assign rd_data  = empty ? 4'h0 : mem_q[rd_ptr_q];

endmodule

// File: tb/tb_hex_key_fifo.sv
// Bench for hex_key_fifo: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_hex_key_fifo;

  localparam int unsigned DEPTH       = 8;
  localparam int unsigned HOLDOFF_CYC = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] key_code = '0;
  logic       key_valid = 1'b0;
  logic       rd_en = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [3:0] rd_data;
  logic       empty;
  logic       full;
  logic [3:0] count;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  hex_key_fifo #(.DEPTH(DEPTH), .HOLDOFF_CYC(HOLDOFF_CYC)) dut (
    .clock(clock), .reset(reset), .key_code(key_code), .key_valid(key_valid),
    .rd_en(rd_en), .ovf_clr(ovf_clr), .rd_data(rd_data), .empty(empty),
    .full(full), .count(count), .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a key is taken if the filter was never primed since reset,
  // the code differs from the last accepted one, or more than HOLDOFF_CYC edges
  // have passed since the last key_valid edge.
  logic [3:0] mq[$];
  logic       m_ovf = 1'b0;
  logic       m_fresh = 1'b1;
  logic       m_valid = 1'b0;
  logic [3:0] m_last = '0;
  int         m_edge = 0;
  int         m_last_ev = 0;

  always @(posedge clock) begin
    logic acc, pp, ps;
    m_edge++;
    if (reset) begin
      mq.delete();
      m_ovf   = 1'b0;
      m_fresh = 1'b1;
      m_last  = '0;
      m_valid = 1'b1;
    end else begin
      acc = key_valid && (m_fresh || key_code != m_last || (m_edge - m_last_ev) > HOLDOFF_CYC);
      pp  = rd_en && mq.size() > 0;
      ps  = acc && (mq.size() < DEPTH || pp);
      if (pp) void'(mq.pop_front());
      if (ps) mq.push_back(key_code);
      if (acc && !ps)   m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      if (key_valid) begin
        m_last_ev = m_edge;
        m_fresh   = 1'b0;
        if (acc) m_last = key_code;
      end
    end
  end

  always @(negedge clock) begin
    if (m_valid) begin
      check("model_rd_data",  32'(rd_data),  32'(mq.size() > 0 ? mq[0] : 4'h0));
      check("model_empty",    32'(empty),    32'(mq.size() == 0));
      check("model_full",     32'(full),     32'(mq.size() == DEPTH));
      check("model_count",    32'(count),    32'(mq.size()));
      check("model_overflow", 32'(overflow), 32'(m_ovf));
    end
  end

  task automatic tick(input logic r, input logic kv, input logic [3:0] code,
                      input logic rd, input logic clr);
    reset = r; key_valid = kv; key_code = code; rd_en = rd; ovf_clr = clr;
    @(posedge clock);
    #1;
    reset = 1'b0; key_valid = 1'b0; key_code = '0; rd_en = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic pulse(input logic [3:0] code);
    tick(1'b0, 1'b1, code, 1'b0, 1'b0);
  endtask

  task automatic pop1();
    tick(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
  endtask

  initial begin
    @(posedge clock);
    #1;
    tick(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_overflow", 32'(overflow), 0);

    // 1: single accept then pop
    pulse(4'hA);
    check("t1_count", 32'(count), 1);
    check("t1_empty", 32'(empty), 0);
    check("t1_rd_data", 32'(rd_data), 32'hA);
    pop1();
    check("t1_pop_empty", 32'(empty), 1);
    check("t1_pop_rd_data", 32'(rd_data), 0);

    // 2: held key and hold-off timing
    for (int i = 0; i < 10; i++) begin
      pulse(4'h5);
      check("t2_hold_count", 32'(count), 1);
    end
    for (int i = 0; i < 3; i++) begin
      idle(7);
      pulse(4'h5);
      check("t2_repeat_count", 32'(count), 1);
    end
    idle(16);
    pulse(4'h5);
    check("t2_after16_count", 32'(count), 2);
    idle(15);
    pulse(4'h5);
    check("t2_after15_count", 32'(count), 2);
    pop1();
    check("t2_pop_rd_data", 32'(rd_data), 32'h5);
    pop1();
    check("t2_drain_empty", 32'(empty), 1);

    // 3: interleaved codes
    pulse(4'h3);
    pulse(4'h7);
    idle(1);
    pulse(4'h3);
    check("t3_count", 32'(count), 3);
    check("t3_head0", 32'(rd_data), 32'h3);
    pop1();
    check("t3_head1", 32'(rd_data), 32'h7);
    pop1();
    check("t3_head2", 32'(rd_data), 32'h3);
    pop1();
    check("t3_empty", 32'(empty), 1);

    // 4: fill, overflow (set wins over clear), drain, clear
    for (int i = 1; i <= 8; i++) pulse(4'(i));
    check("t4_full", 32'(full), 1);
    check("t4_no_ovf_yet", 32'(overflow), 0);
    tick(1'b0, 1'b1, 4'h9, 1'b0, 1'b1);
    check("t4_overflow", 32'(overflow), 1);
    check("t4_count", 32'(count), 8);
    for (int i = 1; i <= 8; i++) begin
      check("t4_pop_order", 32'(rd_data), 32'(i));
      pop1();
    end
    check("t4_empty", 32'(empty), 1);
    check("t4_ovf_sticky", 32'(overflow), 1);
    tick(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    check("t4_ovf_clr", 32'(overflow), 0);

    // 5: push+pop on full, then on empty
    for (int i = 0; i < 8; i++) pulse(4'(i));
    check("t5_full", 32'(full), 1);
    tick(1'b0, 1'b1, 4'hF, 1'b1, 1'b0);
    check("t5_count", 32'(count), 8);
    check("t5_overflow", 32'(overflow), 0);
    for (int i = 1; i <= 7; i++) begin
      check("t5_pop_order", 32'(rd_data), 32'(i));
      pop1();
    end
    check("t5_last_out", 32'(rd_data), 32'hF);
    pop1();
    check("t5_empty", 32'(empty), 1);
    tick(1'b0, 1'b1, 4'hE, 1'b1, 1'b0);
    check("t5_empty_pushpop_count", 32'(count), 1);
    check("t5_empty_pushpop_data", 32'(rd_data), 32'hE);
    pop1();

    // 6: reset mid-operation
    for (int i = 1; i <= 9; i++) pulse(4'(i));
    for (int i = 0; i < 3; i++) pop1();
    check("t6_pre_count", 32'(count), 5);
    check("t6_pre_ovf", 32'(overflow), 1);
    tick(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    check("t6_rst_count", 32'(count), 0);
    check("t6_rst_empty", 32'(empty), 1);
    check("t6_rst_ovf", 32'(overflow), 0);
    pulse(4'h9);
    check("t6_repeat_count", 32'(count), 1);
    check("t6_repeat_data", 32'(rd_data), 32'h9);

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
